uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path of the UART bus wrapper between NUM_REQ byte producers, e.g. the music player status, the command echo and the debug dump.
- Grants one byte at a time, round-robin, and drives tx_data_valid/tx_data_in into the bus.
- The bus exposes no busy flag, so the arbiter times each frame itself and holds off the next byte until the frame and a guard gap have elapsed.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- BPS_PARA, 10, clk cycles per UART bit; must equal the value given to the UART bus.
- GAP_CYCLES, 2, extra idle cycles after each frame before the next grant; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  NUM_REQ  bit i: requester i holds a byte
- req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i]
- req_lock  input  NUM_REQ  bit i: requester i asks to keep the grant (used only with the macro)
- req_ready  output  NUM_REQ  one-cycle pulse: byte of requester i accepted
- tx_data_valid  output  1  one-cycle pulse to the UART bus tx_data_valid
- tx_data_in  output  8  byte to the UART bus
- busy  output  1  high while a frame is being timed
- grant_id  output  max(1,clog2(NUM_REQ))  index of the last granted requester

Behaviour:
- Reset (rst=1 at a clk edge):
  - req_ready, tx_data_valid, tx_data_in, busy, grant_id all 0.
  - State IDLE, rr_ptr=0, counter 0.
  - Reset mid-frame abandons timing; the UART line may finish its frame on its own.
- Frame timing: FRAME_CYCLES = 10*BPS_PARA (start, 8 data, stop). WAIT_LEN = FRAME_CYCLES + GAP_CYCLES. Counter width is clog2(WAIT_LEN).
- IDLE:
  - At a clk edge with req_valid != 0, the winner w is the first set bit searching from rr_ptr upward with wrap-around.
  - Registered on that edge: tx_data_in <= req_data[w], tx_data_valid <= 1, req_ready[w] <= 1 (all other bits 0), grant_id <= w, busy <= 1, counter <= 0, state -> WAIT.
  - With req_valid == 0: stay in IDLE, outputs unchanged except the pulses, which stay 0.
- WAIT:
  - tx_data_valid and req_ready return to 0 after exactly one cycle.
  - req_valid is ignored throughout WAIT.
  - Counter increments each cycle. When counter == WAIT_LEN-1: busy <= 0, rr_ptr <= (w+1) mod NUM_REQ, state -> IDLE.
- Latency and throughput:
  - Request to pulse is 1 edge when IDLE.
  - Consecutive tx_data_valid pulses are at least WAIT_LEN+1 cycles apart (103 with the defaults).
- Handshake:
  - A requester holds req_valid and req_data stable until it sees req_ready.
  - It must drop req_valid, or present the next byte, in the cycle after req_ready. Because the arbiter is in WAIT during that cycle, no double grant is possible.
- Requests that appear and disappear between edges are never seen. A requester that withdraws req_valid before it is granted loses nothing.
- No state exists beyond IDLE and WAIT; a glitch-free 1-bit state register is sufficient.

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- Defined:
  - At the WAIT->IDLE transition, if req_lock[grant_id] is 1, rr_ptr stays at grant_id.
  - That requester then wins the next IDLE arbitration whenever its req_valid is 1, so multi-byte messages go out uninterrupted.
  - If its req_valid is 0 in IDLE, normal round-robin applies, starting at grant_id+1.
- Undefined: req_lock is ignored, with pure round-robin as above. The port remains present and unconnected internally.

Test Plan (NUM_REQ=4, BPS_PARA=10, GAP_CYCLES=2):
- Hold rst=1 for 3 cycles with random inputs -> all outputs 0; first edge after release with req_valid=0 keeps busy=0.
- req_valid=4'b0010, req_data byte1=8'hA5 -> next edge tx_data_valid=1 for exactly 1 cycle with tx_data_in=8'hA5, req_ready=4'b0010, grant_id=1; busy high for 102 cycles; the UART bus tx line decodes 0xA5.
- All four requesters valid from reset, each dropping valid after its ready -> grants in order 0,1,2,3; tx_data_valid pulses 103 cycles apart; bytes appear in the same order.
- Requesters 0 and 2 valid continuously -> grant_id sequence 0,2,0,2; requester 1 never granted.
- rst=1 for one cycle at WAIT cycle 50 with requester 3 valid -> busy=0 and rr_ptr=0 after reset; requester 3 is granted on the first edge after release without waiting for the old frame.
- UART_ARB_LOCK_EN defined: requester 1 sends 3 bytes with req_lock=1 while requester 0 is valid -> grants 1,1,1 then 0; without the macro -> grants 1,0,1,0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit path between NUM_REQ producers.
// Ports: clk, rst (sync, active-high); req_valid/req_data/req_lock in;
//   req_ready, tx_data_valid, tx_data_in, busy, grant_id out.
//   The UART bus has no busy flag, so each frame plus a guard gap is timed here.
//   Optional macro UART_ARB_LOCK_EN: a locked requester keeps the grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BPS_PARA   = 10,
  parameter int GAP_CYCLES = 2,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_lock,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   tx_data_valid,
  output logic [7:0]             tx_data_in,
  output logic                   busy,
  output logic [IW-1:0]          grant_id
);

  localparam int FRAME_CYCLES = 10 * BPS_PARA;
  localparam int WAIT_LEN     = FRAME_CYCLES + GAP_CYCLES;
  localparam int CW           = $clog2(WAIT_LEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_LEN - 1);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [CW-1:0]    cnt;

  logic             win_hit;
  logic [IW-1:0]    win_idx;
  logic [7:0]       win_byte;
  logic [IW-1:0]    rr_next;

  // Scan from the highest offset down so the lowest offset
  // from rr_ptr (first in wrap-around order) wins.
  always_comb begin
    int idx;
    win_hit  = 1'b0;
    win_idx  = '0;
    win_byte = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (req_valid[IW'(idx)]) begin
        win_hit  = 1'b1;
        win_idx  = IW'(idx);
        win_byte = req_data[8*idx +: 8];
      end
    end
  end

  always_comb begin
    int n;
    n = int'(grant_id) + 1;
    if (n >= NUM_REQ)
      n = 0;
    rr_next = IW'(n);
`ifdef UART_ARB_LOCK_EN
    if (req_lock[grant_id])
      rr_next = grant_id;
`endif
  end

`ifndef UART_ARB_LOCK_EN
  logic lock_unused;
  assign lock_unused = ^req_lock;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      rr_ptr        <= '0;
      cnt           <= '0;
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
      tx_data_in    <= '0;
      busy          <= 1'b0;
      grant_id      <= '0;
    end else begin
      req_ready     <= '0;
      tx_data_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (win_hit) begin
            tx_data_in    <= win_byte;
            tx_data_valid <= 1'b1;
            req_ready     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
            grant_id      <= win_idx;
            busy          <= 1'b1;
            cnt           <= '0;
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            busy   <= 1'b0;
            rr_ptr <= rr_next;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
